// File: rtl/slow_tick_monitor.sv
// rtl/slow_tick_monitor.sv - measures rise-to-rise period of a slow divided clock, with lock and timeout flags.
// Optional high-time measurement is built when SLOW_TICK_HIGH_TIME_EN is defined.
module slow_tick_monitor #(
    parameter int                CNT_W         = 26,
    parameter logic [CNT_W-1:0]  TIMEOUT_LIMIT = 26'd40_000_000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             divided_clk,
    output logic             tick_rise,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
`ifdef SLOW_TICK_HIGH_TIME_EN
    ,
    output logic             tick_fall,
    output logic [CNT_W-1:0] high_time
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_TO_THRESH = TIMEOUT_LIMIT - {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_vld;
    logic             r_seen_low;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_tick_rise;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_timeout;
    state_t           r_state;
    state_t           w_next_state;
    logic             w_rise;
    logic             w_to_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    // An edge only counts once a real low has passed the synchronizer, so a
    // level already high at reset release never looks like a rise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_vld      <= 2'b00;
            r_seen_low <= 1'b0;
        end else begin
            r_s1       <= divided_clk;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_vld      <= {r_vld[0], 1'b1};
            r_seen_low <= r_seen_low | (r_vld[1] & ~r_s2);
        end
    end

    assign w_rise    = r_s2 & ~r_s3 & r_seen_low;
    assign w_to_hit  = (r_cnt == LP_TO_THRESH) & ~w_rise;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_rise) begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_MEASURE;
                ST_MEASURE: w_next_state = ST_TRACK;
                ST_TRACK:   w_next_state = ST_TRACK;
                default:    w_next_state = ST_IDLE;
            endcase
        end else if (w_to_hit) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_rise    <= 1'b0;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_tick_rise <= w_rise;
            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_rise) begin
                r_timeout <= 1'b0;
                // The first rise after IDLE is only a reference edge.
                if (r_state != ST_IDLE) begin
                    r_period       <= w_cnt_inc;
                    r_period_valid <= 1'b1;
                    r_locked       <= (r_state == ST_TRACK) && (w_cnt_inc == r_period);
                end
            end else if (w_to_hit) begin
                r_timeout      <= 1'b1;
                r_period_valid <= 1'b0;
                r_locked       <= 1'b0;
            end
        end
    end

    assign tick_rise    = r_tick_rise;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

`ifdef SLOW_TICK_HIGH_TIME_EN
    logic             w_fall;
    logic             r_tick_fall;
    logic [CNT_W-1:0] r_high_time;

    assign w_fall = ~r_s2 & r_s3 & r_seen_low;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_fall <= 1'b0;
            r_high_time <= '0;
        end else begin
            r_tick_fall <= w_fall;
            if (w_fall) begin
                r_high_time <= w_cnt_inc;
            end
        end
    end

    assign tick_fall = r_tick_fall;
    assign high_time = r_high_time;
`endif

endmodule

// File: tb/tb_slow_tick_monitor.sv
// tb/tb_slow_tick_monitor.sv - scoreboard bench for slow_tick_monitor against an edge-timestamp model.
module tb_slow_tick_monitor;

    localparam int CNT_W = 26;
    localparam int T_LIM = 100;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             divided_clk = 1'b0;
    logic             tick_rise;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
`ifdef SLOW_TICK_HIGH_TIME_EN
    logic             tick_fall;
    logic [CNT_W-1:0] high_time;
`endif

    slow_tick_monitor #(
        .CNT_W         (CNT_W),
        .TIMEOUT_LIMIT (26'd100)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .divided_clk  (divided_clk),
        .tick_rise    (tick_rise),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
`ifdef SLOW_TICK_HIGH_TIME_EN
        ,
        .tick_fall    (tick_fall),
        .high_time    (high_time)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int   cyc;
        logic tick;
        int   per;
        logic pv;
        logic lk;
        logic to;
    } ev_t;

    ev_t q_exp[$];
    int  q_fall_cyc[$];
    int  q_fall_ht[$];
    int  n_checks = 0;
    int  n_fail = 0;

    // Model state: edge timestamps in clk_in cycles since reset release.
    int   k;
    bit   have_prev, prev_lvl, seen_low;
    int   pend_rise[$];
    int   pend_fall[$];
    int   last_r;
    int   mode;
    int   m_per;
    logic m_pv, m_lk, m_to;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0; have_prev = 0; prev_lvl = 0; seen_low = 0; last_r = 0; mode = 0;
        m_per = 0; m_pv = 0; m_lk = 0; m_to = 0;
        pend_rise.delete(); pend_fall.delete();
        q_exp.delete(); q_fall_cyc.delete(); q_fall_ht.delete();
    endtask

    task automatic model_step();
        ev_t e;
        int  p;
        k++;
        if (have_prev && !prev_lvl && divided_clk) pend_rise.push_back(k + 2);
        if (have_prev && prev_lvl && !divided_clk && seen_low) pend_fall.push_back(k + 2);
        if (!divided_clk) seen_low = 1;
        prev_lvl = divided_clk;
        have_prev = 1;
        if (pend_fall.size() > 0 && pend_fall[0] == k) begin
            void'(pend_fall.pop_front());
            q_fall_cyc.push_back(k);
            q_fall_ht.push_back(k - last_r);
        end
        if (pend_rise.size() > 0 && pend_rise[0] == k) begin
            void'(pend_rise.pop_front());
            p = k - last_r;
            m_to = 0;
            if (mode == 0) begin
                mode = 1;
            end else begin
                m_lk = (mode == 2) && (p == m_per);
                m_per = p;
                m_pv = 1;
                mode = 2;
            end
            last_r = k;
            e = '{cyc: k, tick: 1'b1, per: m_per, pv: m_pv, lk: m_lk, to: 1'b0};
            q_exp.push_back(e);
        end else if (k - last_r == T_LIM) begin
            mode = 0; m_to = 1; m_pv = 0; m_lk = 0;
            e = '{cyc: k, tick: 1'b0, per: m_per, pv: 1'b0, lk: 1'b0, to: 1'b1};
            q_exp.push_back(e);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: pops an expectation whenever the DUT presents a tick or a new timeout.
    initial begin
        ev_t  e;
        logic prev_to;
        prev_to = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst_n) begin
                while (q_exp.size() > 0 && q_exp[0].cyc < k) begin
                    e = q_exp.pop_front();
                    chk("missed_event_cycle", k, e.cyc);
                end
                if (tick_rise || (timeout && !prev_to)) begin
                    if (q_exp.size() == 0) begin
                        chk("unexpected_event_tick", int'(tick_rise), 0);
                    end else begin
                        e = q_exp.pop_front();
                        chk("event_cycle", k, e.cyc);
                        chk("tick_rise", int'(tick_rise), int'(e.tick));
                        chk("period", int'(period), e.per);
                        chk("period_valid", int'(period_valid), int'(e.pv));
                        chk("locked", int'(locked), int'(e.lk));
                        chk("timeout", int'(timeout), int'(e.to));
                    end
                end
`ifdef SLOW_TICK_HIGH_TIME_EN
                while (q_fall_cyc.size() > 0 && q_fall_cyc[0] < k) begin
                    chk("missed_fall_cycle", k, q_fall_cyc.pop_front());
                    void'(q_fall_ht.pop_front());
                end
                if (tick_fall) begin
                    if (q_fall_cyc.size() == 0) begin
                        chk("unexpected_tick_fall", 1, 0);
                    end else begin
                        chk("fall_cycle", k, q_fall_cyc.pop_front());
                        chk("high_time", int'(high_time), q_fall_ht.pop_front());
                    end
                end
`endif
                prev_to = timeout;
            end else begin
                prev_to = 1'b0;
            end
        end
    end

    task automatic wave(input int hi, input int lo);
        divided_clk = 1'b1;
        repeat (hi) @(negedge clk_in);
        divided_clk = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick_rise"}, int'(tick_rise), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_period_valid"}, int'(period_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (hold) @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    initial begin
        int h;
        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        repeat (6) wave(10, 10);
        repeat (3) wave(12, 12);
        repeat (8) wave($urandom_range(3, 30), $urandom_range(3, 30));
        for (int i = 0; i < 4; i++) begin
            h = $urandom_range(3, 25);
            repeat (3) wave(h, h);
        end
        repeat (3) wave(10, 10);
        repeat (120) @(negedge clk_in);
        repeat (3) wave(10, 10);
        repeat (4) wave(50, 50);
        wave(50, 51);
        repeat (3) wave(10, 10);
        divided_clk = 1'b1;
        repeat (4) @(negedge clk_in);
        async_reset(2);
        divided_clk = 1'b0;
        repeat (4) wave(10, 10);
        divided_clk = 1'b1;
        async_reset(2);
        repeat (15) @(negedge clk_in);
        divided_clk = 1'b0;
        repeat (3) wave(10, 10);
        repeat (4) wave(7, 13);
        repeat (5) @(negedge clk_in);
        chk("queue_drained", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
